// File: rtl/ub_master.sv
// ub_master: ARM-register-controlled UNIBUS master. It requests the bus with
// NPR, runs one DATI/DATO/DATOB cycle with deskew/settle timing and slave
// handshake timeouts, and reports status and read data back to the ARM.
module ub_master #(
  parameter int DESKEW  = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  input  logic        npg_in_h,
  input  logic        bbsy_in_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h
);

  localparam int CW = $clog2(DESKEW + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEL,
    ST_SETUP,
    ST_MSYN,
    ST_RELEASE,
    ST_SETTLE
  } state_t;

  state_t        state_reg, state_next;
  logic          busy_reg, busy_next;
  logic          timeout_err_reg, timeout_err_next;
  logic [17:0]   addr_reg, addr_next;
  logic [1:0]    c_reg, c_next;
  logic [15:0]   wdata_reg, wdata_next;
  logic [15:0]   rdata_reg, rdata_next;
  logic [15:0]   lastwait_reg, lastwait_next;
  logic [15:0]   wait_reg, wait_next;
  logic [CW-1:0] counter_reg, counter_next;
  logic [TW-1:0] timer_reg, timer_next;

  logic          npr_reg, npr_next;
  logic          sack_reg, sack_next;
  logic          bbsy_reg, bbsy_next;
  logic          msyn_reg, msyn_next;
  logic [17:0]   a_reg, a_next;
  logic [1:0]    c_out_reg, c_out_next;
  logic [15:0]   d_out_reg, d_out_next;

  // Bits of the reg1 write word that carry no meaning.
  logic unused_wdata_bits;
  assign unused_wdata_bits = &{1'b0, armwdata[30], armwdata[27:18]};

  assign npr_out_h  = npr_reg;
  assign sack_out_h = sack_reg;
  assign bbsy_out_h = bbsy_reg;
  assign msyn_out_h = msyn_reg;
  assign a_out_h    = a_reg;
  assign c_out_h    = c_out_reg;
  assign d_out_h    = d_out_reg;

  // ARM read-back mux, combinational from armraddr.
  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      2'd0: armrdata = 32'h554D1002;
      2'd1: armrdata = {busy_reg, timeout_err_reg, c_reg, 10'b0, addr_reg};
      2'd2: armrdata = {rdata_reg, wdata_reg};
      default: armrdata = {16'b0, lastwait_reg};
    endcase
  end

  // Next-state and next-output logic: ARM register loads, bus sequencing, INIT override.
  always_comb begin
    state_next       = state_reg;
    busy_next        = busy_reg;
    timeout_err_next = timeout_err_reg;
    addr_next        = addr_reg;
    c_next           = c_reg;
    wdata_next       = wdata_reg;
    rdata_next       = rdata_reg;
    lastwait_next    = lastwait_reg;
    wait_next        = wait_reg;
    counter_next     = counter_reg;
    timer_next       = timer_reg;
    npr_next         = npr_reg;
    sack_next        = sack_reg;
    bbsy_next        = bbsy_reg;
    msyn_next        = msyn_reg;
    a_next           = a_reg;
    c_out_next       = c_out_reg;
    d_out_next       = d_out_reg;

    // Register loads only happen while idle; busy is set exactly when the FSM leaves IDLE.
    if (armwrite && !busy_reg) begin
      case (armwaddr)
        2'd1: begin
          timeout_err_next = 1'b0;
          if (armwdata[31]) begin
            addr_next  = armwdata[17:0];
            c_next     = armwdata[29:28];
            busy_next  = 1'b1;
            npr_next   = 1'b1;
            state_next = ST_REQ;
          end
        end
        2'd2: wdata_next = armwdata[15:0];
        default: ;
      endcase
    end

    case (state_reg)
      ST_REQ: begin
        if (npg_in_h) begin
          sack_next  = 1'b1;
          npr_next   = 1'b0;
          state_next = ST_SEL;
        end
      end
      ST_SEL: begin
        // Become bus master only once grant, other master and previous slave have all let go.
        if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
          bbsy_next    = 1'b1;
          sack_next    = 1'b0;
          a_next       = addr_reg;
          c_out_next   = c_reg;
          d_out_next   = c_reg[1] ? wdata_reg : 16'h0;
          counter_next = CW'(DESKEW);
          state_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (counter_reg <= CW'(1)) begin
          counter_next = '0;
          msyn_next    = 1'b1;
          timer_next   = TW'(TIMEOUT);
          wait_next    = 16'h0;
          state_next   = ST_MSYN;
        end else begin
          counter_next = counter_reg - CW'(1);
        end
      end
      ST_MSYN: begin
        if (ssyn_in_h) begin
          if (!c_reg[1]) rdata_next = d_in_h;
          lastwait_next = (wait_reg == 16'hFFFF) ? 16'hFFFF : wait_reg + 16'h1;
          msyn_next     = 1'b0;
          timer_next    = TW'(TIMEOUT);
          state_next    = ST_RELEASE;
        end else if (timer_reg <= TW'(1)) begin
          msyn_next        = 1'b0;
          timeout_err_next = 1'b1;
          timer_next       = TW'(TIMEOUT);
          state_next       = ST_RELEASE;
        end else begin
          timer_next = timer_reg - TW'(1);
          wait_next  = (wait_reg == 16'hFFFF) ? 16'hFFFF : wait_reg + 16'h1;
        end
      end
      ST_RELEASE: begin
        if (!ssyn_in_h) begin
          counter_next = CW'(DESKEW);
          state_next   = ST_SETTLE;
        end else if (timer_reg <= TW'(1)) begin
          timeout_err_next = 1'b1;
          counter_next     = CW'(DESKEW);
          state_next       = ST_SETTLE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      ST_SETTLE: begin
        if (counter_reg <= CW'(1)) begin
          counter_next = '0;
          a_next       = 18'h0;
          c_out_next   = 2'b0;
          d_out_next   = 16'h0;
          bbsy_next    = 1'b0;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else begin
          counter_next = counter_reg - CW'(1);
        end
      end
      default: ;
    endcase

    // Bus INIT aborts whatever is in progress; an interrupted cycle is reported as an error.
    if (init_in_h) begin
      if (busy_reg) timeout_err_next = 1'b1;
      busy_next    = 1'b0;
      state_next   = ST_IDLE;
      npr_next     = 1'b0;
      sack_next    = 1'b0;
      bbsy_next    = 1'b0;
      msyn_next    = 1'b0;
      a_next       = 18'h0;
      c_out_next   = 2'b0;
      d_out_next   = 16'h0;
      counter_next = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_reg       <= ST_IDLE;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      addr_reg        <= 18'h0;
      c_reg           <= 2'b0;
      wdata_reg       <= 16'h0;
      rdata_reg       <= 16'h0;
      lastwait_reg    <= 16'h0;
      wait_reg        <= 16'h0;
      counter_reg     <= '0;
      timer_reg       <= '0;
      npr_reg         <= 1'b0;
      sack_reg        <= 1'b0;
      bbsy_reg        <= 1'b0;
      msyn_reg        <= 1'b0;
      a_reg           <= 18'h0;
      c_out_reg       <= 2'b0;
      d_out_reg       <= 16'h0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= busy_next;
      timeout_err_reg <= timeout_err_next;
      addr_reg        <= addr_next;
      c_reg           <= c_next;
      wdata_reg       <= wdata_next;
      rdata_reg       <= rdata_next;
      lastwait_reg    <= lastwait_next;
      wait_reg        <= wait_next;
      counter_reg     <= counter_next;
      timer_reg       <= timer_next;
      npr_reg         <= npr_next;
      sack_reg        <= sack_next;
      bbsy_reg        <= bbsy_next;
      msyn_reg        <= msyn_next;
      a_reg           <= a_next;
      c_out_reg       <= c_out_next;
      d_out_reg       <= d_out_next;
    end
  end

endmodule

// File: tb/tb_ub_master.sv
// tb_ub_master: drives ub_master through DATI, DATO, DATOB, timeout,
// contention and INIT scenarios with a simple slave/arbiter model.
module tb_ub_master;

  localparam int DESKEW  = 15;
  localparam int TIMEOUT = 1000;

  logic        CLOCK;
  logic        RESET_N;
  logic        armwrite;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        init_in_h;
  logic        npg_in_h;
  logic        bbsy_in_h;
  logic        ssyn_in_h;
  logic [15:0] d_in_h;
  logic        npr_out_h;
  logic        sack_out_h;
  logic        bbsy_out_h;
  logic        msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  logic [39:0] bus_all;
  assign bus_all = {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h};

  int checks = 0;
  int errors = 0;

  // Expected-result scoreboard.
  logic [63:0] sb_exp_q[$];
  string       sb_tag_q[$];

  // Bench-side model of the ARM-visible registers.
  logic [15:0] exp_wdata    = 16'h0;
  logic [15:0] exp_rdata    = 16'h0;
  logic [15:0] exp_lastwait = 16'h0;

  ub_master #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .init_in_h(init_in_h), .npg_in_h(npg_in_h), .bbsy_in_h(bbsy_in_h),
    .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h),
    .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h),
    .msyn_out_h(msyn_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb_tag_q.push_back(tag);
    sb_exp_q.push_back(v);
  endtask

  task automatic sb_pop_check(input logic [63:0] got);
    string tag;
    logic [63:0] exp;
    check("sb_nonempty", 64'(sb_exp_q.size() > 0), 64'(1));
    if (sb_exp_q.size() > 0) begin
      tag = sb_tag_q.pop_front();
      exp = sb_exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    tick();
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    armraddr = a;
    #1;
    v = armrdata;
  endtask

  // One complete master cycle with a cooperating arbiter/slave model.
  // ssyn_dly = 0 means the slave never answers; do_init pulses INIT during MSYN.
  task automatic run_txn(input string name, input logic [1:0] c, input logic [17:0] addr,
                         input int grant_dly, input bit contend, input int ssyn_dly,
                         input logic [15:0] din, input bit do_init);
    logic [31:0] rv;
    logic [15:0] exp_d;
    logic        err_exp;
    int          cnt;
    int          viol;

    exp_d = c[1] ? exp_wdata : 16'h0;
    if (do_init) begin
      err_exp = 1'b1;
    end else begin
      err_exp = (ssyn_dly == 0);
      if (ssyn_dly > 0) begin
        if (!c[1]) exp_rdata = din;
        exp_lastwait = 16'(ssyn_dly);
      end
    end
    sb_push({name, "_bus_idle"}, 64'h0);
    sb_push({name, "_reg1_end"}, {32'b0, 1'b0, err_exp, c, 10'b0, addr});
    sb_push({name, "_reg2_end"}, {32'b0, exp_rdata, exp_wdata});
    sb_push({name, "_reg3_end"}, {48'b0, exp_lastwait});

    arm_write(2'd1, {1'b1, 1'b0, c, 10'b0, addr});
    rd(2'd1, rv);
    check({name, "_reg1_start"}, 64'(rv), 64'({1'b1, 1'b0, c, 10'b0, addr}));
    check({name, "_npr"}, 64'(npr_out_h), 64'(1));

    repeat (grant_dly) tick();
    npg_in_h  = 1'b1;
    bbsy_in_h = contend;
    cnt = 0;
    while (!sack_out_h && cnt < 10) begin tick(); cnt++; end
    check({name, "_sack"}, 64'({sack_out_h, npr_out_h}), 64'(2'b10));
    npg_in_h = 1'b0;

    if (contend) begin
      viol = 0;
      repeat (50) begin
        tick();
        if (!sack_out_h || bbsy_out_h) viol++;
      end
      bbsy_in_h = 1'b0;
      check({name, "_contend_hold"}, 64'(viol), 64'(0));
    end

    cnt = 0;
    while (!bbsy_out_h && cnt < 10) begin tick(); cnt++; end
    check({name, "_bbsy"}, 64'({bbsy_out_h, sack_out_h}), 64'(2'b10));

    viol = 0;
    cnt  = 0;
    while (!msyn_out_h && cnt < DESKEW + 5) begin
      if (a_out_h !== addr || c_out_h !== c || d_out_h !== exp_d || !bbsy_out_h) viol++;
      tick();
      cnt++;
    end
    check({name, "_deskew"}, 64'(cnt), 64'(DESKEW));

    if (do_init) begin
      // Both writes land while busy and must be ignored.
      arm_write(2'd1, {1'b1, 1'b0, 2'b11, 10'b0, 18'o000252});
      arm_write(2'd2, 32'h0000BEEF);
      init_in_h = 1'b1;
      tick();
      init_in_h = 1'b0;
    end else begin
      cnt = 0;
      while (msyn_out_h && cnt < TIMEOUT + 5) begin
        if (a_out_h !== addr || c_out_h !== c || d_out_h !== exp_d || !bbsy_out_h) viol++;
        if (ssyn_dly > 0 && cnt == ssyn_dly - 1) begin
          ssyn_in_h = 1'b1;
          d_in_h    = din;
        end
        tick();
        cnt++;
      end
      check({name, "_msyn_len"}, 64'(cnt), 64'(ssyn_dly > 0 ? ssyn_dly : TIMEOUT));
      ssyn_in_h = 1'b0;
      d_in_h    = 16'h0;

      cnt = 0;
      while (bbsy_out_h && cnt < DESKEW + TIMEOUT + 10) begin
        if (a_out_h !== addr || c_out_h !== c || d_out_h !== exp_d) viol++;
        tick();
        cnt++;
      end
      check({name, "_settle_len"}, 64'(cnt), 64'(DESKEW + 1));
      check({name, "_field_hold"}, 64'(viol), 64'(0));
    end

    sb_pop_check(64'(bus_all));
    rd(2'd1, rv); sb_pop_check(64'(rv));
    rd(2'd2, rv); sb_pop_check(64'(rv));
    rd(2'd3, rv); sb_pop_check(64'(rv));
    $display("txn %s c=%0d addr=%o ssyn_dly=%0d contend=%0d init=%0d done",
             name, c, addr, ssyn_dly, contend, do_init);
  endtask

  initial begin
    logic [31:0] rv;
    RESET_N   = 1'b0;
    armwrite  = 1'b0;
    armraddr  = 2'd0;
    armwaddr  = 2'd0;
    armwdata  = 32'h0;
    init_in_h = 1'b0;
    npg_in_h  = 1'b0;
    bbsy_in_h = 1'b0;
    ssyn_in_h = 1'b0;
    d_in_h    = 16'h0;

    // Reset must win over a simultaneous start request.
    armwrite = 1'b1;
    armwaddr = 2'd1;
    armwdata = {1'b1, 1'b0, 2'b10, 10'b0, 18'o777560};
    repeat (3) tick();
    armwrite = 1'b0;
    RESET_N  = 1'b1;
    tick();
    check("reset_bus", 64'(bus_all), 64'h0);
    rd(2'd0, rv); check("reset_reg0", 64'(rv), 64'h554D1002);
    rd(2'd1, rv); check("reset_reg1", 64'(rv), 64'h0);
    rd(2'd2, rv); check("reset_reg2", 64'(rv), 64'h0);
    rd(2'd3, rv); check("reset_reg3", 64'(rv), 64'h0);
    $display("txn reset done");

    // DATI from 777560, slave returns 000200 after 20 cycles.
    run_txn("dati", 2'b00, 18'o777560, 3, 1'b0, 20, 16'o000200, 1'b0);

    // DATO of 0x0041 to 777566; data bus must not be captured.
    arm_write(2'd2, 32'h0000_0041);
    exp_wdata = 16'h0041;
    run_txn("dato", 2'b10, 18'o777566, 2, 1'b0, 5, 16'hFFFF, 1'b0);

    // DATOB to an odd address: address bit 0 and full word pass through.
    run_txn("datob", 2'b11, 18'o777561, 0, 1'b0, 3, 16'h5A5A, 1'b0);

    // No slave response.
    run_txn("nossyn", 2'b00, 18'o777570, 1, 1'b0, 0, 16'h0, 1'b0);

    // Next start clears the error; another master holds BBSY for 50 cycles.
    run_txn("contend", 2'b00, 18'o777572, 2, 1'b1, 7, 16'h1234, 1'b0);

    // INIT during MSYN, with ignored writes while busy beforehand.
    run_txn("init", 2'b00, 18'o777574, 1, 1'b0, 0, 16'h0, 1'b1);

    // reg1 write with bit31 clear while idle only clears the error.
    arm_write(2'd1, {1'b0, 1'b0, 2'b11, 10'b0, 18'o000001});
    rd(2'd1, rv);
    check("errclr_reg1", 64'(rv), 64'({1'b0, 1'b0, 2'b00, 10'b0, 18'o777574}));
    check("errclr_bus", 64'(bus_all), 64'h0);
    $display("txn errclr done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
